// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among N_PORTS cores.
// A lock keeps the bus with one owner across an AMO sequence; reads can time out.
module dmem_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [N_PORTS-1:0]                req_re,
  input  logic [N_PORTS-1:0]                req_we,
  input  logic [N_PORTS-1:0]                req_lock,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     req_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     req_wdata,
  input  logic [N_PORTS*DATA_WIDTH/8-1:0]   req_mask,
  output logic [N_PORTS-1:0]                gnt,
  output logic [N_PORTS-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              mem_re,
  output logic                              mem_we,
  output logic [DATA_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic [DATA_WIDTH/8-1:0]           mem_mask,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_rvalid
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int MW = DATA_WIDTH / 8;
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOCKED, RD_WAIT} state_e;

  state_e                state_q, state_d, ret_q, ret_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d, lock_owner_q, lock_owner_d, owner_q, owner_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [N_PORTS-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [N_PORTS-1:0]    cand;
  logic                  found;
  logic [PW-1:0]         win;

  assign cand = req_re | req_we;

  // Winner selection: only the lock owner while LOCKED, round-robin from rr_ptr in IDLE.
  always_comb begin
    found = 1'b0;
    win   = '0;
    if (state_q == LOCKED) begin
      found = cand[lock_owner_q];
      win   = lock_owner_q;
    end else if (state_q == IDLE) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (!found && cand[(int'(rr_ptr_q) + k) % N_PORTS]) begin
          found = 1'b1;
          win   = PW'((int'(rr_ptr_q) + k) % N_PORTS);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    owner_d      = owner_q;
    tmo_d        = tmo_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    gnt          = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_mask     = '0;
    case (state_q)
      IDLE, LOCKED: begin
        if (found) begin
          gnt[win]  = 1'b1;
          mem_we    = req_we[win];
          mem_re    = ~req_we[win];   // re&we collapses to a write
          mem_addr  = req_addr[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          mem_wdata = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          mem_mask  = req_mask[int'(win)*MW +: MW];
          if (state_q == IDLE)
            rr_ptr_d = (int'(win) == N_PORTS-1) ? '0 : win + 1'b1;
          if (req_lock[win])
            lock_owner_d = win;
          if (req_we[win]) begin
            state_d = req_lock[win] ? LOCKED : IDLE;
          end else begin
            state_d = RD_WAIT;
            owner_d = win;
            ret_d   = req_lock[win] ? LOCKED : IDLE;
          end
        end else if (state_q == LOCKED && !req_lock[lock_owner_q]) begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = mem_rdata;
          state_d              = ret_q;
          tmo_d                = '0;
        end else if (tmo_q == TW'(RD_TIMEOUT-1)) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = 1'b1;
          state_d              = ret_q;
          tmo_d                = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      owner_q      <= '0;
      tmo_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      owner_q      <= owner_d;
      tmo_q        <= tmo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_arbiter;
  localparam int NP = 2, DW = 32, MW = DW/8, TO = 64;

  logic clk = 1'b0, arst_n = 1'b0;
  logic [NP-1:0] req_re = '0, req_we = '0, req_lock = '0;
  logic [NP*DW-1:0] req_addr = '0, req_wdata = '0;
  logic [NP*MW-1:0] req_mask = '0;
  logic [NP-1:0] gnt, rsp_valid;
  logic [DW-1:0] rsp_rdata, mem_addr, mem_wdata;
  logic rsp_err, mem_re, mem_we;
  logic [MW-1:0] mem_mask;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_rvalid = 1'b0;

  dmem_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .arst_n(arst_n), .req_re(req_re), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc_n = 0;

  // Transaction-level model: who may use the bus, outstanding read and its deadline.
  int m_rr, m_lock_own, m_own, m_age;
  bit m_locked, m_busy, m_ret_locked;
  logic [NP-1:0] m_rsp_v;
  logic [DW-1:0] m_rsp_d;
  logic m_rsp_e;

  logic [NP-1:0] obs_gnt, obs_rsp_valid;
  logic [DW-1:0] obs_rdata, obs_addr;
  logic obs_err, obs_re, obs_we;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lock_own = 0; m_own = 0; m_age = 0;
    m_locked = 0; m_busy = 0; m_ret_locked = 0;
    m_rsp_v = '0; m_rsp_d = '0; m_rsp_e = 1'b0;
  endtask

  task automatic model_step();
    int w;
    logic [NP-1:0] eg;
    logic e_re, e_we;
    logic [DW-1:0] e_addr, e_wd;
    logic [MW-1:0] e_mask;
    if (!arst_n) model_reset();
    w = -1;
    if (!m_busy) begin
      if (m_locked) begin
        if (req_re[m_lock_own] | req_we[m_lock_own]) w = m_lock_own;
      end else begin
        for (int k = 0; k < NP; k++)
          if (w < 0 && (req_re[(m_rr+k)%NP] | req_we[(m_rr+k)%NP])) w = (m_rr+k)%NP;
      end
    end
    eg = '0; e_re = 0; e_we = 0; e_addr = '0; e_wd = '0; e_mask = '0;
    if (w >= 0) begin
      eg[w] = 1'b1; e_we = req_we[w]; e_re = ~req_we[w];
      e_addr = req_addr[w*DW +: DW]; e_wd = req_wdata[w*DW +: DW]; e_mask = req_mask[w*MW +: MW];
    end
    chk("gnt", gnt, eg);
    chk("mem_re", mem_re, e_re);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_mask", mem_mask, e_mask);
    chk("rsp_valid", rsp_valid, m_rsp_v);
    chk("rsp_rdata", rsp_rdata, m_rsp_d);
    chk("rsp_err", rsp_err, m_rsp_e);
    obs_gnt = gnt; obs_rsp_valid = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err;
    obs_re = mem_re; obs_we = mem_we; obs_addr = mem_addr;
    m_rsp_v = '0; m_rsp_d = '0; m_rsp_e = 1'b0;
    if (!arst_n) return;
    if (m_busy) begin
      if (mem_rvalid) begin
        m_rsp_v[m_own] = 1'b1; m_rsp_d = mem_rdata; m_busy = 0; m_locked = m_ret_locked;
      end else begin
        m_age++;
        if (m_age == TO) begin
          m_rsp_v[m_own] = 1'b1; m_rsp_e = 1'b1; m_busy = 0; m_locked = m_ret_locked;
        end
      end
    end else if (w >= 0) begin
      if (!m_locked) m_rr = (w + 1) % NP;
      if (req_lock[w]) m_lock_own = w;
      if (req_we[w]) m_locked = req_lock[w];
      else begin m_busy = 1; m_own = w; m_age = 0; m_ret_locked = req_lock[w]; end
    end else if (m_locked && !req_lock[m_lock_own]) begin
      m_locked = 0;
    end
  endtask

  // One clock: check at the falling edge, return just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic clear_inputs();
    req_re = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    arst_n = 1'b0;
    cyc(); cyc();
    arst_n = 1'b1;
    cyc_n = 0;
  endtask

  // Random requesters: hold until granted; AMO = locked read, wait response, locked write, unlock.
  bit have[NP];
  int amo[NP];
  logic r_re[NP], r_we[NP], r_lk[NP];
  logic [DW-1:0] r_addr[NP], r_wd[NP];
  logic [MW-1:0] r_mask[NP];
  int due[$];

  task automatic rand_drive(input bit noise);
    bit hit;
    for (int p = 0; p < NP; p++) begin
      if (have[p] && obs_gnt[p]) begin
        have[p] = 0;
        if (amo[p] == 1) amo[p] = 2;
        else if (amo[p] == 3) begin amo[p] = 0; r_lk[p] = 0; end
      end
      if (amo[p] == 2 && obs_rsp_valid[p]) begin
        amo[p] = 3; have[p] = 1; r_re[p] = 0; r_we[p] = 1; r_lk[p] = 1; r_wd[p] = $urandom;
      end
      if (!have[p] && amo[p] == 0 && $urandom_range(1, 0) == 1) begin
        int k;
        k = $urandom_range(7, 0);
        have[p] = 1; r_addr[p] = $urandom; r_wd[p] = $urandom; r_mask[p] = MW'($urandom);
        r_lk[p] = 0; r_re[p] = 0; r_we[p] = 0;
        if (k <= 2 || k == 7) r_we[p] = 1;
        else if (k <= 4) r_re[p] = 1;
        else if (k == 5) begin r_re[p] = 1; r_we[p] = 1; end
        else begin r_re[p] = 1; r_lk[p] = 1; amo[p] = 1; end
      end
      req_re[p] = have[p] & r_re[p];
      req_we[p] = have[p] & r_we[p];
      req_lock[p] = r_lk[p];
      req_addr[p*DW +: DW] = r_addr[p];
      req_wdata[p*DW +: DW] = r_wd[p];
      req_mask[p*MW +: MW] = r_mask[p];
    end
    if (obs_re && $urandom_range(9, 0) != 0) due.push_back(cyc_n - 1 + $urandom_range(5, 1));
    hit = 0;
    for (int i = due.size() - 1; i >= 0; i--)
      if (due[i] <= cyc_n) begin
        if (due[i] == cyc_n) hit = 1;
        due.delete(i);
      end
    mem_rvalid = hit | (noise && $urandom_range(15, 0) == 0);
    mem_rdata = $urandom;
  endtask

  int cnt;

  initial begin
    model_reset();
    for (int p = 0; p < NP; p++) begin
      have[p] = 0; amo[p] = 0; r_re[p] = 0; r_we[p] = 0; r_lk[p] = 0;
      r_addr[p] = '0; r_wd[p] = '0; r_mask[p] = '0;
    end
    #1;
    do_reset();
    chk("reset_gnt", obs_gnt, 0);
    chk("reset_rsp", obs_rsp_valid, 0);

    // Both ports write every cycle: strict alternation starting at port 0.
    req_we = 2'b11; req_addr = {32'h200, 32'h100}; req_mask = '1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("alt_gnt", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_addr", obs_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
    end

    // Port 1 read, memory answers 3 cycles after the grant.
    do_reset();
    req_re = 2'b10; req_addr = {32'h40, 32'h0};
    cyc();
    chk("rd_gnt", obs_gnt, 2'b10);
    chk("rd_mem_re", obs_re, 1);
    chk("rd_addr", obs_addr, 32'h40);
    req_re = '0;
    cyc(); chk("rd_wait_re1", obs_re, 0);
    cyc(); chk("rd_wait_re2", obs_re, 0);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    cyc(); chk("rd_no_early_rsp", obs_rsp_valid, 0);
    mem_rvalid = 0; mem_rdata = '0;
    cyc();
    chk("rd_rsp_valid", obs_rsp_valid, 2'b10);
    chk("rd_rsp_data", obs_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", obs_err, 0);

    // AMO on port 0 while port 1 keeps writing.
    do_reset();
    req_re = 2'b01; req_lock = 2'b01; req_we = 2'b10; req_addr = {32'h300, 32'h80};
    cnt = 0;
    cyc(); chk("amo_rd_gnt", obs_gnt, 2'b01); cnt += int'(obs_gnt[1]);
    req_re = '0;
    cyc(); cnt += int'(obs_gnt[1]);
    mem_rvalid = 1; mem_rdata = 32'h1234;
    cyc(); cnt += int'(obs_gnt[1]);
    mem_rvalid = 0;
    cyc(); chk("amo_rsp", obs_rsp_valid, 2'b01); cnt += int'(obs_gnt[1]);
    req_we = 2'b11; req_wdata = {32'h0, 32'h1235};
    cyc(); chk("amo_wr_gnt", obs_gnt, 2'b01); chk("amo_wr_addr", obs_addr, 32'h80);
    cnt += int'(obs_gnt[1]);
    req_we = 2'b10; req_lock = '0;
    cyc(); chk("amo_unlock_gap", obs_gnt, 0); cnt += int'(obs_gnt[1]);
    chk("amo_p1_starved", cnt, 0);
    cyc(); chk("amo_p1_after", obs_gnt, 2'b10);
    req_we = '0;

    // Read with no memory answer times out.
    do_reset();
    req_re = 2'b01; req_addr = '0;
    cyc(); chk("to_gnt", obs_gnt, 2'b01);
    req_re = '0;
    cnt = 0;
    for (int i = 0; i < TO; i++) begin cyc(); cnt += int'(|obs_rsp_valid); end
    chk("to_no_early", cnt, 0);
    cyc();
    chk("to_rsp", obs_rsp_valid, 2'b01);
    chk("to_err", obs_err, 1);
    chk("to_data", obs_rdata, 0);
    req_we = 2'b10;
    cyc(); chk("to_back_idle", obs_gnt, 2'b10);
    req_we = '0;

    // re and we together behave as a write.
    do_reset();
    req_re = 2'b01; req_we = 2'b01; req_addr = {32'h0, 32'h44};
    cyc();
    chk("rw_gnt", obs_gnt, 2'b01); chk("rw_we", obs_we, 1); chk("rw_re", obs_re, 0);
    req_re = '0; req_we = '0;
    mem_rvalid = 1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin cyc(); cnt += int'(|obs_rsp_valid); mem_rvalid = 0; end
    chk("rw_no_rsp", cnt, 0);

    // Reset during a read: response is dropped and arbitration restarts at port 0.
    do_reset();
    req_re = 2'b10;
    cyc(); chk("ar_gnt", obs_gnt, 2'b10);
    req_re = '0;
    #2 arst_n = 1'b0;
    cyc();
    chk("ar_rst_gnt", obs_gnt, 0); chk("ar_rst_rsp", obs_rsp_valid, 0);
    arst_n = 1'b1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    cyc();
    mem_rvalid = 0;
    cyc(); chk("ar_no_rsp", obs_rsp_valid, 0);
    req_we = 2'b11;
    cyc(); chk("ar_rr0", obs_gnt, 2'b01);
    req_we = '0;

    // Randomized traffic, first with well-behaved memory, then with stray rvalid pulses.
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      for (int p = 0; p < NP; p++) begin have[p] = 0; amo[p] = 0; r_lk[p] = 0; end
      due.delete();
      obs_gnt = '0; obs_rsp_valid = '0; obs_re = 0;
      for (int i = 0; i < 800; i++) begin
        rand_drive(ph == 1);
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
